// File: rtl/uart2pwm_pkg.sv
// Shared constants and parser state encoding for the uart2pwm_multi PWM bank.
package uart2pwm_pkg;
  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_IDX_MSB  = 6;
  localparam int CMD_IDX_LSB  = 0;
  localparam int TIMEOUT_MULT = 20;

  typedef enum logic [1:0] {
    PS_IDLE      = 2'd0,
    PS_WAIT_DATA = 2'd1,
    PS_EXEC      = 2'd2
  } parse_state_t;
endpackage

// File: rtl/uart2pwm_uart.sv
// 8N1 UART: rx synchroniser and byte receiver, plus reply serialiser.
// The serialiser exists only when UART2PWM_READBACK_EN is defined; otherwise tx idles high.
module uart2pwm_uart
  import uart2pwm_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx
);
  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          rx_s1, rx_s2, rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        // Half a bit after the edge: a high line here was a glitch, not a start bit.
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == BIT_LAST) begin
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef UART2PWM_READBACK_EN
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_left;
  logic [7:0]    tx_sh;
  logic          tx_busy;

  // A start request while busy is dropped rather than queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_left <= '0;
      tx_sh   <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx      <= 1'b0;
        tx_sh   <= tx_data;
        tx_left <= 4'd9;
        tx_cnt  <= '0;
        tx_busy <= 1'b1;
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt <= '0;
      if (tx_left == 4'd0) begin
        tx_busy <= 1'b0;
      end else begin
        tx      <= (tx_left == 4'd1) ? 1'b1 : tx_sh[0];
        tx_sh   <= {1'b0, tx_sh[7:1]};
        tx_left <= tx_left - 1'b1;
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end
`else
  logic unused_tx;
  assign unused_tx = ^{tx_start, tx_data};
  assign tx        = 1'b1;
`endif
endmodule

// File: rtl/uart2pwm_multi.sv
// UART-controlled PWM bank: command parser, shadow/active duty registers, shared counter.
// Readback replies on tx are built only when UART2PWM_READBACK_EN is defined.
module uart2pwm_multi
  import uart2pwm_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int PWM_BITS = 8,
  parameter int CLK_DIV  = 434
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic [CHANNELS-1:0] pwm,
  output logic                tx
);
  localparam int                  TO_LAST  = TIMEOUT_MULT * CLK_DIV - 1;
  localparam int                  TW       = $clog2(TIMEOUT_MULT * CLK_DIV);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  logic [7:0]          rx_data, tx_data;
  logic                rx_valid, tx_start;
  parse_state_t        state;
  logic [7:0]          cmd_q;
  logic [PWM_BITS-1:0] data_q;
  logic [TW-1:0]       to_cnt;
  logic [PWM_BITS-1:0] shadow [CHANNELS];
  logic [PWM_BITS-1:0] active [CHANNELS];
  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] rd_duty;
  logic [6:0]          idx;
  logic                is_wr, idx_ok, wrap;

  uart2pwm_uart #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx)
  );

  assign idx    = cmd_q[CMD_IDX_MSB:CMD_IDX_LSB];
  assign is_wr  = cmd_q[CMD_WR_BIT];
  assign idx_ok = int'(idx) < CHANNELS;
  assign wrap   = (cnt == CNT_LAST);

  always_comb begin
    rd_duty = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (idx == 7'(i)) rd_duty = shadow[i];
  end

  assign tx_start = (state == PS_EXEC) && idx_ok;
  assign tx_data  = is_wr ? 8'(data_q) : 8'(rd_duty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= PS_IDLE;
      cmd_q  <= '0;
      data_q <= '0;
      to_cnt <= '0;
    end else begin
      case (state)
        PS_IDLE: begin
          if (rx_valid) begin
            cmd_q  <= rx_data;
            to_cnt <= '0;
            state  <= rx_data[CMD_WR_BIT] ? PS_WAIT_DATA : PS_EXEC;
          end
        end
        // A stalled WRITE is abandoned so a lost data byte cannot pair with the next command.
        PS_WAIT_DATA: begin
          if (rx_valid) begin
            data_q <= rx_data[PWM_BITS-1:0];
            state  <= PS_EXEC;
          end else if (to_cnt == TW'(TO_LAST)) begin
            state <= PS_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= PS_IDLE;
      endcase
    end
  end

  // Active duties change only at the wrap, so a period never sees two duty values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pwm <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        if (wrap) active[i] <= shadow[i];
        if (state == PS_EXEC && is_wr && idx == 7'(i)) shadow[i] <= data_q;
        pwm[i] <= (cnt < active[i]);
      end
    end
  end
endmodule

// File: tb/tb_uart2pwm_multi.sv
// Self-checking bench for uart2pwm_multi: reply scoreboard on tx, duty model on pwm.
module tb_uart2pwm_multi;
  localparam int CLK_DIV  = 16;
  localparam int CHANNELS = 8;
  localparam int PWM_BITS = 8;
  localparam int PERIOD   = 255;
`ifdef UART2PWM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                rx  = 1'b1;
  logic [CHANNELS-1:0] pwm;
  logic                tx;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         exp_duty[CHANNELS];
  logic       mon_abort = 1'b0;

  always #5 clk = ~clk;

  uart2pwm_multi #(.CHANNELS(CHANNELS), .PWM_BITS(PWM_BITS), .CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .pwm (pwm),
    .tx  (tx)
  );

  always @(posedge rst) mon_abort = 1'b1;

  // Reply monitor: decodes each tx frame at mid-bit and checks it against the scoreboard.
  initial begin
    logic [7:0] got;
    logic [7:0] want;
    logic       frame_ok;
    forever begin
      @(negedge tx);
      mon_abort = 1'b0;
      repeat (CLK_DIV / 2) @(posedge clk);
      #1 frame_ok = (tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(posedge clk);
        #1 got[i] = tx;
      end
      repeat (CLK_DIV) @(posedge clk);
      #1 frame_ok = frame_ok & (tx === 1'b1);
      if (!mon_abort) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_reply: got 0x%02h, no reply expected", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want || !frame_ok) begin
            n_fail++;
            $display("FAIL reply: got 0x%02h framing_ok=%0b, want 0x%02h framing_ok=1",
                     got, frame_ok, want);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 rx = fr[i];
      repeat (CLK_DIV - 1) @(posedge clk);
    end
    @(posedge clk);
    #1 rx = 1'b1;
  endtask

  task automatic send_write(input int ch, input logic [7:0] val);
    if (ch < CHANNELS) begin
      exp_duty[ch] = val;
      if (RB) exp_q.push_back(val);
    end
    send_byte(8'h80 | 8'(ch), 1'b1);
    send_byte(val, 1'b1);
  endtask

  task automatic send_read(input int ch);
    if (ch < CHANNELS && RB) exp_q.push_back(8'(exp_duty[ch]));
    send_byte(8'(ch), 1'b1);
  endtask

  task automatic settle();
    repeat (300) @(posedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < CHANNELS; i++) exp_duty[i] = 0;
    exp_q.delete();
  endtask

  task automatic check_pwm(input string name, input int periods);
    int hi[CHANNELS];
    for (int c = 0; c < CHANNELS; c++) hi[c] = 0;
    repeat (periods * PERIOD) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CHANNELS; c++) if (pwm[c] === 1'b1) hi[c]++;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      n_checks++;
      if (hi[c] !== exp_duty[c] * periods) begin
        n_fail++;
        $display("FAIL %s ch%0d: got %0d high cycles in %0d, want %0d",
                 name, c, hi[c], periods * PERIOD, exp_duty[c] * periods);
      end
    end
  endtask

  task automatic wait_replies(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s: %0d replies outstanding, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    n_checks++;
    if (pwm !== '0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in: pwm=0x%02h tx=%b, want 0x00 1", pwm, tx);
    end
    #1 rst = 1'b0;
    clear_model();
    for (int i = 0; i < 10; i++) begin
      repeat (2 * PERIOD / 10) @(posedge clk);
      #1;
      n_checks++;
      if (pwm !== '0 || tx !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold: pwm=0x%02h tx=%b, want 0x00 1", pwm, tx);
      end
    end
  endtask

  task automatic test_write();
    send_write(3, 8'h40);
    settle();
    check_pwm("write", 1);
    wait_replies("write_reply");
  endtask

  task automatic test_extremes();
    send_write(0, 8'hFF);
    send_write(1, 8'h00);
    settle();
    check_pwm("extremes", 3);
    wait_replies("extremes_reply");
  endtask

  task automatic test_readback();
    int lows = 0;
    send_read(3);
    if (!RB) begin
      repeat (400) begin
        @(posedge clk);
        #1 if (tx !== 1'b1) lows++;
      end
      n_checks++;
      if (lows !== 0) begin
        n_fail++;
        $display("FAIL readback_off: tx low for %0d cycles, want 0", lows);
      end
    end
    wait_replies("readback");
  endtask

  task automatic test_error_frames();
    send_byte(8'h8A, 1'b1);
    send_byte(8'h55, 1'b1);
    settle();
    check_pwm("bad_index", 1);
    send_byte(8'h81, 1'b1);
    repeat (25 * 10 * CLK_DIV) @(posedge clk);
    send_write(2, 8'h10);
    settle();
    check_pwm("timeout", 1);
    send_byte(8'h84, 1'b0);
    repeat (2 * CLK_DIV) @(posedge clk);
    send_byte(8'h20, 1'b1);
    settle();
    check_pwm("framing", 1);
    wait_replies("error_frames");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h83, 1'b1);
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (pwm !== '0 || tx !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_mid_rx: pwm=0x%02h tx=%b, want 0x00 1", pwm, tx);
        end
      end
    join
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    settle();
    check_pwm("after_rst_rx", 1);

    send_write(4, 8'h30);
    settle();
    wait_replies("pre_mid_reply");
    send_read(4);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (pwm !== '0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_tx: pwm=0x%02h tx=%b, want 0x00 1", pwm, tx);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    repeat (200) @(posedge clk);
    send_write(6, 8'h99);
    settle();
    check_pwm("after_rst_tx", 1);
    wait_replies("after_rst_reply");
  endtask

  initial begin
    test_reset();
    test_write();
    test_extremes();
    test_readback();
    test_error_frames();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
